// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, VRAM geometry and the fetch FSM
// state type shared by the scanout block and any overlay built on the
// timing generator.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int unsigned VRAM_W       = 640;
  localparam int unsigned VRAM_LINES   = 480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: h/v raster counters advancing on pix_en, with registered
// active/hsync/vsync/frame_start one pixel behind the counter state.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter logic        SYNC_ACT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic in_active;
  logic in_hsync;
  logic in_vsync;
  logic at_origin;

  // Decode the current raster position into region flags
  always_comb begin
    in_active = (h < H_VIS) && (v < V_VIS);
    in_hsync  = (h >= HS_BEG) && (h < HS_END);
    in_vsync  = (v >= VS_BEG) && (v < VS_END);
    at_origin = (h == '0) && (v == '0);
  end

  // Raster counters: h wraps at end of line, v steps on h wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 10'd1;
      end else begin
        h <= h + 10'd1;
      end
    end
  end

  // Output stage: region flags registered on the same pixel tick
  always_ff @(posedge clk) begin
    if (rst) begin
      active      <= 1'b0;
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && at_origin;
      if (pix_en) begin
        active <= in_active;
        hsync  <= in_hsync ? SYNC_ACT : ~SYNC_ACT;
        vsync  <= in_vsync ? SYNC_ACT : ~SYNC_ACT;
      end
    end
  end

endmodule

// File: rtl/vram_scanout.sv
// vram_scanout: read side of the 1-bpp line VRAM. Generates VGA timing,
// prefetches the next visible line during horizontal blanking through the
// read_req/vram_turn handshake, double-buffers it and shifts it out MSB-first.
// Optional: define VRAM_SCANOUT_UNDERRUN_CNT_EN to add a saturating 16-bit
// underrun_cnt output.
module vram_scanout
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter logic        SYNC_ACT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic [VRAM_W-1:0] line_from_vram,
  input  logic              vram_turn,
  output logic              read_req,
  output logic [8:0]        line_addr,
  output logic              pixel,
  output logic              active,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start,
  output logic              underrun
`ifdef VRAM_SCANOUT_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS   = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS   = 10'(V_ACTIVE);
  localparam logic [9:0] PIX_MSB = 10'(H_ACTIVE - 1);

  logic [9:0] h;
  logic [9:0] v;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_ACT (SYNC_ACT)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .h           (h),
    .v           (v),
    .active      (active),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  fetch_state_t state_q;
  fetch_state_t state_d;

  logic [VRAM_W-1:0] fetch_buf;
  logic [VRAM_W-1:0] disp_buf;
  logic              fetched;

  logic [9:0] v_next;
  logic       next_vis;
  logic       trigger;
  logic       swap;
  logic       load_addr;
  logic       latch_line;
  logic       visible;
  logic [9:0] pix_idx;

  // Line-turn events; v_next wraps to 0 after the last blanking line so a
  // single "< V_ACTIVE" test covers both the next-row and new-frame cases
  always_comb begin
    v_next   = (v == V_LAST) ? '0 : v + 10'd1;
    next_vis = (v_next < V_VIS);
    trigger  = pix_en && (h == H_VIS) && next_vis;
    swap     = pix_en && (h == H_LAST) && next_vis;
    visible  = (h < H_VIS) && (v < V_VIS);
    pix_idx  = PIX_MSB - h;
  end

  // Fetch FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch FSM next state; a swap outranks a same-cycle grant in REQ
  always_comb begin
    state_d    = state_q;
    read_req   = 1'b0;
    load_addr  = 1'b0;
    latch_line = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d   = REQ;
          load_addr = 1'b1;
        end
      end
      REQ: begin
        read_req = 1'b1;
        if (swap) begin
          state_d = IDLE;
        end else if (vram_turn) begin
          state_d    = DONE;
          latch_line = 1'b1;
        end
      end
      DONE: begin
        if (swap) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line buffers, request address and sticky underrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      line_addr <= '0;
      fetch_buf <= '0;
      disp_buf  <= '0;
      fetched   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (load_addr) begin
        line_addr <= v_next[8:0];
      end
      if (latch_line) begin
        fetch_buf <= line_from_vram;
        fetched   <= 1'b1;
      end
      if (swap) begin
        fetched <= 1'b0;
        if (fetched) begin
          disp_buf <= fetch_buf;
        end else begin
          disp_buf <= '0;
          underrun <= 1'b1;
        end
      end
    end
  end

  // Pixel serialiser, registered on the same tick as the timing outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel <= 1'b0;
    end else if (pix_en) begin
      pixel <= visible ? disp_buf[pix_idx] : 1'b0;
    end
  end

`ifdef VRAM_SCANOUT_UNDERRUN_CNT_EN
  // Saturating count of lines shown blank after a missed fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (swap && !fetched && (underrun_cnt != '1)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_scanout.sv
// tb_vram_scanout: self-checking bench with a line-level reference model of
// the raster, the prefetch handshake and the displayed line contents.
`timescale 1ns/1ps
module tb_vram_scanout;

  localparam int HT  = 800;
  localparam int VA  = 24;
  localparam int VT  = 31;
  localparam int HS0 = 656;
  localparam int HS1 = 752;
  localparam int VS0 = 26;
  localparam int VS1 = 28;

  logic         clk = 1'b0;
  logic         rst;
  logic         pix_en;
  logic         vram_turn;
  logic [639:0] line_from_vram;
  logic         read_req;
  logic [8:0]   line_addr;
  logic         pixel;
  logic         active;
  logic         hsync;
  logic         vsync;
  logic         frame_start;
  logic         underrun;
`ifdef VRAM_SCANOUT_UNDERRUN_CNT_EN
  logic [15:0]  underrun_cnt;
`endif

  always #5 clk = ~clk;

  vram_scanout #(
    .V_ACTIVE (24),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pix_en         (pix_en),
    .line_from_vram (line_from_vram),
    .vram_turn      (vram_turn),
    .read_req       (read_req),
    .line_addr      (line_addr),
    .pixel          (pixel),
    .active         (active),
    .hsync          (hsync),
    .vsync          (vsync),
    .frame_start    (frame_start),
    .underrun       (underrun)
`ifdef VRAM_SCANOUT_UNDERRUN_CNT_EN
    ,
    .underrun_cnt   (underrun_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // VRAM contents
  logic [639:0] vram [VA];

  // Reference model state
  int           mh = 0, mv = 0, mfr = 0;
  int           nl;
  bit           nvis, mswap;
  logic [639:0] cur;
  logic         got, e_req;
  logic [8:0]   e_addr;
  logic         e_pix, e_act, e_hs, e_vs, e_fs, e_und;
  int           e_cnt;
  logic         upd;
  bit           started = 0;
  int           o_row, o_col, o_frm;

  // Reference model: raster position, line events and displayed content
  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      mh = 0; mv = 0; cur = '0; got = 0; e_req = 0; e_addr = '0;
      e_pix = 0; e_act = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_und = 0;
      e_cnt = 0; upd = 0;
    end else begin
      nvis  = (mv == VT-1) || (mv + 1 < VA);
      nl    = (mv == VT-1) ? 0 : mv + 1;
      mswap = pix_en && (mh == HT-1) && nvis;
      if (e_req && vram_turn && !mswap) begin
        got = 1; e_req = 0;
      end
      e_fs = 0;
      upd  = pix_en;
      if (pix_en) begin
        e_act = (mh < 640) && (mv < VA);
        e_pix = e_act ? cur[639 - mh] : 1'b0;
        e_hs  = !((mh >= HS0) && (mh < HS1));
        e_vs  = !((mv >= VS0) && (mv < VS1));
        e_fs  = (mh == 0) && (mv == 0);
        o_row = mv; o_col = mh; o_frm = mfr;
        if (mh == 640 && nvis) begin
          e_req = 1; e_addr = 9'(nl); got = 0;
        end
        if (mswap) begin
          if (got) cur = vram[nl];
          else begin
            cur = '0; e_und = 1;
            if (e_cnt < 65535) e_cnt++;
          end
          got = 0; e_req = 0;
        end
        if (mh == HT-1) begin
          mh = 0;
          if (mv == VT-1) begin mv = 0; mfr++; end
          else mv++;
        end else mh++;
      end
    end
  end

  // Literal trackers
  int hs_run = 0, vs_run = 0, gap = 0;
  bit have_fs = 0;
  int ones5 = 0, first5 = -1, last5 = -1, ones10 = 0, ones11 = 0, ones20 = 0;
  bit saw5 = 0, saw0 = 0;

  // Compare process: every cycle against the model, plus width/period checks
  always @(negedge clk) begin
    if (started) begin
      chk("pixel", {31'd0, pixel}, {31'd0, e_pix});
      chk("active", {31'd0, active}, {31'd0, e_act});
      chk("hsync", {31'd0, hsync}, {31'd0, e_hs});
      chk("vsync", {31'd0, vsync}, {31'd0, e_vs});
      chk("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
      chk("underrun", {31'd0, underrun}, {31'd0, e_und});
      chk("read_req", {31'd0, read_req}, {31'd0, e_req});
      chk("line_addr", {23'd0, line_addr}, {23'd0, e_addr});
`ifdef VRAM_SCANOUT_UNDERRUN_CNT_EN
      chk("underrun_cnt", {16'd0, underrun_cnt}, 32'(e_cnt));
`endif
      if (rst) begin
        hs_run = 0; vs_run = 0; have_fs = 0; gap = 0;
      end else if (upd) begin
        if (!hsync) hs_run++;
        else if (hs_run != 0) begin chk("hsync_width", 32'(hs_run), 32'd96); hs_run = 0; end
        if (!vsync) vs_run++;
        else if (vs_run != 0) begin chk("vsync_width", 32'(vs_run), 32'(2*HT)); vs_run = 0; end
        gap++;
        if (frame_start) begin
          if (have_fs) chk("frame_period", 32'(gap), 32'(HT*VT));
          have_fs = 1; gap = 0;
        end
        if (o_col < 640 && pixel) begin
          if (o_frm == 0 && o_row == 5) begin
            ones5++;
            if (first5 < 0) first5 = o_col;
            last5 = o_col;
          end
          if (o_frm == 1 && o_row == 10) ones10++;
          if (o_frm == 1 && o_row == 11) ones11++;
          if (o_frm == 1 && o_row == 20) ones20++;
        end
      end
      if (read_req && line_addr == 9'd5 && mv == 4) saw5 = 1;
      if (read_req && line_addr == 9'd0 && mv == VT-1) saw0 = 1;
    end
  end

  // Stimulus controls
  int gmode   = 0;  // 0: grant after latency, 1: stress lines 10/20, 2: never grant
  int pe_mode = 0;  // 0: pix_en always high, 1: random
  bit seen_req = 0;
  int wait_cnt = 0;

  task automatic grant();
    vram_turn = 1'b1;
    if (line_addr < VA) line_from_vram = vram[line_addr];
  endtask

  task automatic cyc();
    @(negedge clk);
    pix_en    = (pe_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    vram_turn = 1'b0;
    for (int k = 0; k < 20; k++) line_from_vram[32*k +: 32] = $urandom();
    if (rst) begin
      seen_req = 0;
    end else if (read_req) begin
      if (!seen_req) begin
        seen_req = 1;
        wait_cnt = (pe_mode == 0) ? 3 : $urandom_range(0, 30);
      end
      if (gmode == 1 && line_addr == 9'd10) begin
        vram_turn = 1'b0;
      end else if (gmode == 1 && line_addr == 9'd20) begin
        if (pix_en && mh == HT-1 && mv == 19) grant();
      end else if (gmode != 2) begin
        if (wait_cnt == 0) grant();
        else wait_cnt--;
      end
    end else begin
      seen_req = 0;
      if (gmode == 1 && $urandom_range(0, 63) == 0) vram_turn = 1'b1;
    end
  endtask

  int ones_rst;

  initial begin
    rst = 1'b1; pix_en = 1'b0; vram_turn = 1'b0; line_from_vram = '0;
    for (int l = 0; l < VA; l++) begin
      for (int k = 0; k < 20; k++) vram[l][32*k +: 32] = $urandom();
      vram[l][0] = 1'b1;
    end
    vram[5] = {1'b1, 638'd0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_read_req", {31'd0, read_req}, 32'd0);
    chk("rst_line_addr", {23'd0, line_addr}, 32'd0);
    chk("rst_pixel", {31'd0, pixel}, 32'd0);
    chk("rst_hsync", {31'd0, hsync}, 32'd1);
    chk("rst_vsync", {31'd0, vsync}, 32'd1);
    chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    rst = 1'b0; pix_en = 1'b1;

    // Frame 1: continuous pixels, fixed grant latency
    for (int i = 0; i < 30000 && mfr < 1; i++) cyc();
    chk("frame1_done", 32'(mfr), 32'd1);
    chk("f1_underrun", {31'd0, underrun}, 32'd0);
    chk("line5_ones", 32'(ones5), 32'd2);
    chk("line5_first", 32'(first5), 32'd0);
    chk("line5_last", 32'(last5), 32'd639);
    chk("line5_req_in_line4", {31'd0, saw5}, 32'd1);
    chk("line0_req_in_vblank", {31'd0, saw0}, 32'd1);

    // Frame 2: random pix_en, random latency, line 10 withheld, line 20 at swap
    gmode = 1; pe_mode = 1;
    for (int i = 0; i < 60000 && mfr < 2; i++) cyc();
    chk("frame2_done", 32'(mfr), 32'd2);
    chk("f2_underrun", {31'd0, underrun}, 32'd1);
    chk("line10_blank", 32'(ones10), 32'd0);
    chk("line20_blank", 32'(ones20), 32'd0);
    chk("line11_ones", 32'(ones11), 32'($countones(vram[11])));
`ifdef VRAM_SCANOUT_UNDERRUN_CNT_EN
    chk("f2_underrun_cnt", {16'd0, underrun_cnt}, 32'd2);
`endif

    // Reset while a request is outstanding, then a late grant
    gmode = 2; pe_mode = 0;
    for (int i = 0; i < 3000 && !read_req; i++) cyc();
    chk("req_before_rst", {31'd0, read_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_req_read_req", {31'd0, read_req}, 32'd0);
    chk("rst_mid_req_line_addr", {23'd0, line_addr}, 32'd0);
    chk("rst_mid_req_underrun", {31'd0, underrun}, 32'd0);
    rst = 1'b0; pix_en = 1'b1; vram_turn = 1'b1; line_from_vram = '1;
    @(negedge clk);
    chk("restart_frame_start", {31'd0, frame_start}, 32'd1);
    chk("late_turn_read_req", {31'd0, read_req}, 32'd0);
    vram_turn = 1'b0;
    gmode = 0;
    ones_rst = 0;
    for (int i = 0; i < 700; i++) begin
      cyc();
      if (pixel) ones_rst++;
    end
    chk("row0_after_rst_blank", 32'(ones_rst), 32'd0);
    repeat (1600) cyc();
    chk("after_rst_underrun", {31'd0, underrun}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
